vga_scanout: RTL and testbench

Parametrised raster scan-out engine for the GPU video path. It generates VGA sync and data-enable timing for any resolution and sync polarity, and buffers incoming pixels in an internal FIFO fed by a valid/ready stream. During active video it drives one pixel per cycle. Underruns are handled deterministically and resynchronised at every vertical blank.

---
 rtl/vga_scanout.sv | 146 ++++++++++++++
 tb/tb_vga_scanout.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// Raster scan-out engine: VGA sync/DE timing plus a pixel FIFO fed by a valid/ready stream.
// Define SCANOUT_UNDERRUN_STAT_EN to build the saturating underrun counter; otherwise it reads 0.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   pix_data,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   vblank_start,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic [15:0]            underrun_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // one spare code so sync-window ends equal to the total still fit
  localparam int HW    = $clog2(H_TOTAL + 1);
  localparam int VW    = $clog2(V_TOTAL + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int PIX_W = 3 * COLOR_W;

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic             en_q;
  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             active, full, empty, push, pop, vb_hit, flush, hs_on, vs_on;

  assign active    = enable && (h < H_ACT) && (v < V_ACT);
  assign full      = (count == FULL_C);
  assign empty     = (count == '0);
  assign pix_ready = !full && !reset;
  assign push      = pix_valid && pix_ready;
  assign pop       = active && !empty;
  assign vb_hit    = enable && (h == '0) && (v == V_ACT);
  // the FIFO empties at each vblank and once on the falling edge of enable,
  // so pixels pushed while idle survive as a preload
  assign flush     = vb_hit || (en_q && !enable);
  assign hs_on     = enable && (h >= HS_BEG) && (h < HS_END);
  assign vs_on     = enable && (v >= VS_BEG) && (v < VS_END);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h    <= '0;
      v    <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable) begin
        h <= '0;
        v <= '0;
      end else if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (push && !flush) mem[wr_ptr] <= pix_data;
  end

  // single output stage keeps sync, de, colour and vblank_start aligned
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vga_hs       <= !HS_POL;
      vga_vs       <= !VS_POL;
      vga_de       <= 1'b0;
      vblank_start <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      vga_hs       <= hs_on ? HS_POL : !HS_POL;
      vga_vs       <= vs_on ? VS_POL : !VS_POL;
      vga_de       <= active;
      vblank_start <= vb_hit;
      {vga_r, vga_g, vga_b} <= pop ? mem[rd_ptr] : '0;
    end
  end

`ifdef SCANOUT_UNDERRUN_STAT_EN
  logic under;
  assign under = active && empty;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)
      underrun_count <= '0;
    else if (under && (underrun_count != 16'hFFFF))
      underrun_count <= underrun_count + 16'd1;
  end
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a time-based raster model predicts every pin each cycle,
// a separate monitor pops the predictions and compares both polarity variants of the DUT.
module tb_vga_scanout;
  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int D  = 16;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  typedef struct {
    logic        de, hs, vs, vb, rdy;
    logic [11:0] rgb;
    logic [15:0] urc;
  } rec_t;

  logic clk = 1'b0;
  logic rst, en, valid;
  logic [11:0] data;
  logic rdy, vb, hs, vs, de;
  logic [3:0] r, g, b;
  logic [15:0] urc;
  logic rdy2, vb2, hs2, vs2, de2;
  logic [3:0] r2, g2, b2;
  logic [15:0] urc2;

  always #5 clk = ~clk;

  vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .FIFO_DEPTH(D)) dut (
    .vga_clk(clk), .reset(rst), .enable(en), .pix_data(data), .pix_valid(valid),
    .pix_ready(rdy), .vblank_start(vb), .vga_hs(hs), .vga_vs(vs), .vga_de(de),
    .vga_r(r), .vga_g(g), .vga_b(b), .underrun_count(urc));

  vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .FIFO_DEPTH(D)) dut_pol (
    .vga_clk(clk), .reset(rst), .enable(en), .pix_data(data), .pix_valid(valid),
    .pix_ready(rdy2), .vblank_start(vb2), .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .underrun_count(urc2));

  rec_t exp_q[$];
  rec_t e;
  int n_tests = 0;
  int n_fail  = 0;

  // model state: scan time since frame start, pixel FIFO as a queue
  int          m_t;
  logic [11:0] m_q[$];
  logic        m_enq;
  logic [15:0] m_urc;
  rec_t        p;
  // upstream source and control knobs
  int idx, limit, c_next_limit, c_mode;
  logic c_rst, c_en;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("de",        16'(de),        16'(e.de));
      chk("hs_low",    16'(hs),        16'(!e.hs));
      chk("vs_low",    16'(vs),        16'(!e.vs));
      chk("vblank",    16'(vb),        16'(e.vb));
      chk("rgb",       16'({r, g, b}), 16'(e.rgb));
      chk("ready",     16'(rdy),       16'(e.rdy));
      chk("underrun",  urc,            e.urc);
      chk("hs_high",   16'(hs2),       16'(e.hs));
      chk("vs_high",   16'(vs2),       16'(e.vs));
      chk("de_pol",    16'(de2),       16'(e.de));
      chk("rgb_pol",   16'({r2, g2, b2}), 16'(e.rgb));
      chk("vb_pol",    16'(vb2),       16'(e.vb));
      chk("ready_pol", 16'(rdy2),      16'(e.rdy));
      chk("urc_pol",   urc2,           e.urc);
    end
  end

  task automatic model_reset();
    m_t   = 0;
    m_q.delete();
    m_enq = 1'b0;
    m_urc = '0;
    p     = '{default: 0};
  endtask

  // pins after one clock edge, derived from the raster position t -> (t % HT, t / HT)
  task automatic model_edge(output logic acc);
    int h, v;
    acc = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    acc = valid && (m_q.size() < D);
    p   = '{default: 0};
    if (en) begin
      h = m_t % HT;
      v = m_t / HT;
      p.de = (h < HA) && (v < VA);
      p.hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
      p.vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
      p.vb = (h == 0) && (v == VA);
      if (p.de) begin
        if (m_q.size() > 0) p.rgb = m_q.pop_front();
        else if (m_urc != 16'hFFFF) m_urc++;
      end
      if (p.vb) begin
        m_q.delete();
        acc = 1'b0;
      end else if (acc) m_q.push_back(data);
      m_t = (m_t + 1) % FRAME;
    end else begin
      if (m_enq) begin
        m_q.delete();
        acc = 1'b0;
      end else if (acc) m_q.push_back(data);
      m_t = 0;
    end
    m_enq = en;
  endtask

  task automatic step();
    logic acc;
    rec_t x;
    @(posedge clk);
    model_edge(acc);
    if (p.vb) begin
      idx   = 1;
      limit = c_next_limit;
    end else if (acc) idx++;
    #1;
    rst = c_rst;
    en  = c_en;
    case (c_mode)
      0:       begin valid = (idx <= limit); data = 12'(idx); end
      1:       begin valid = ($urandom_range(0, 1) == 1); data = 12'($urandom); end
      default: begin valid = 1'b0; data = '0; end
    endcase
    if (rst) model_reset();
    x = p;
    x.rdy = !rst && (m_q.size() < D);
`ifdef SCANOUT_UNDERRUN_STAT_EN
    x.urc = m_urc;
`else
    x.urc = '0;
`endif
    exp_q.push_back(x);
  endtask

  initial begin
    model_reset();
    idx = 1; limit = 32; c_next_limit = 32;
    c_rst = 1'b1; c_en = 1'b1; c_mode = 0;
    rst = 1'b1; en = 1'b1; valid = 1'b1; data = 12'h001;
    repeat (3) step();

    // preload while idle: 20 offered, 16 fit
    c_rst = 1'b0; c_en = 1'b0; idx = 1; limit = 20;
    repeat (25) step();

    // streaming frames, then one frame short by two pixels, then recovery
    limit = 32; c_en = 1'b1;
    repeat (4 * FRAME) step();
    c_next_limit = 30;
    repeat (FRAME) step();
    c_next_limit = 32;
    repeat (2 * FRAME) step();

    // drop enable while the counters sit at h = 5, v = 2
    for (int i = 0; i < 2 * FRAME && m_t != 2 * HT + 4; i++) step();
    c_mode = 2; c_en = 1'b0;
    step();
    repeat (6) step();
    idx = 1; limit = 32; c_mode = 0; c_en = 1'b1;
    repeat (2 * FRAME) step();

    // random traffic with an idle gap and a mid-frame reset
    c_mode = 1;
    repeat (150) step();
    c_en = 1'b0;
    repeat (5) step();
    c_en = 1'b1;
    repeat (100) step();
    c_rst = 1'b1;
    repeat (2) step();
    c_rst = 1'b0;
    repeat (150) step();
    c_mode = 2;
    step();

    @(negedge clk);
    #1;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
